// File: rtl/seq_mult_pkg.sv
// Shared state encoding for the multiply/accumulate datapath controllers.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator adder with carry-out; clamps to all-ones on carry when ACC_SATURATE_EN is defined,
// otherwise wraps modulo 2^ACC_WIDTH.
module acc_adder #(
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned IN_WIDTH  = 5
) (
   input  logic [ACC_WIDTH-1:0] a,
   input  logic [IN_WIDTH-1:0]  b,
   output logic [ACC_WIDTH-1:0] sum_c,
   output logic                 carry_c
);

   localparam int unsigned SW = ACC_WIDTH + 1;

   logic [SW-1:0] full;

   always_comb begin
      full    = {1'b0, a} + SW'(b);
      carry_c = full[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
      sum_c   = carry_c ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
      sum_c   = full[ACC_WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums BURST accepted products per result word with valid/ready on both sides.
// Optional saturation on overflow: ACC_SATURATE_EN.
module product_accumulator
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned BURST     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH:0]             product,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_WIDTH-1:0]       sum,
   output logic [$clog2(BURST+1)-1:0] count,
   output logic                       overflow
);

   localparam int unsigned CW = $clog2(BURST + 1);
   localparam int unsigned PW = WIDTH + 1;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] sum_d, add_a, add_sum;
   logic [CW-1:0]        count_d, cnt_inc;
   logic [PW-1:0]        add_b;
   logic                 ovf_d, add_carry, accept;

   acc_adder #(
      .ACC_WIDTH (ACC_WIDTH),
      .IN_WIDTH  (PW)
   ) u_acc_adder (
      .a       (add_a),
      .b       (add_b),
      .sum_c   (add_sum),
      .carry_c (add_carry)
   );

   // Gating the product with accept keeps an undriven bus out of the sum.
   always_comb begin
      accept  = in_valid && in_ready;
      add_a   = (state_q == IDLE) ? '0 : sum;
      add_b   = accept ? product : '0;
      cnt_inc = (state_q == IDLE) ? CW'(1) : count + CW'(1);

      state_d = state_q;
      sum_d   = sum;
      count_d = count;
      ovf_d   = overflow;

      if (clear) begin
         state_d = IDLE;
         sum_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  sum_d   = add_sum;
                  count_d = cnt_inc;
                  ovf_d   = ((state_q == ACCUM) && overflow) || add_carry;
                  state_d = (cnt_inc == CW'(BURST)) ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
                  count_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake flags are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sum       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum       <= sum_d;
         count     <= count_d;
         overflow  <= ovf_d;
         in_ready  <= (state_d != HOLD);
         out_valid <= (state_d == HOLD);
      end
   end

endmodule
